id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising edge; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have inputs: if_instr  16  fetched instruction; if_PC_plus_two  16  fetch PC+2; flush  1  branch-taken squash; ex_MemRead  1, ex_rt  3  from ID/EX outputs.
REQ-003 SHALL have write-back inputs: wb_RegWrite  1; wb_write_reg  3; wb_write_data  16.
REQ-004 SHALL have hazard outputs: pc_write  1  PC enable; stall  1  load-use bubble indicator.
REQ-005 SHALL have ID/EX-feed outputs: PC_plus_two 16, Read_data_1 16, Read_data_2 16, immediate 16, ALU_Src 1, ALUOp 2, RegDest 1, rt 3, rd 3, MemRead 1, MemWrite 1, Branch 1, MemtoReg 1, RegWrite 1.

Function
REQ-006 SHALL hold an IF/ID register {instr 16, pc_plus_two 16, valid 1}, updated on rising clk.
REQ-007 SHALL apply priority rst > flush > stall > load: flush clears valid and instr to 0; stall holds all fields; load captures if_instr, if_PC_plus_two, valid=1.
REQ-008 SHALL decode fields: opcode [15:12], rs [11:9], rt [8:6], rd [5:3], imm [5:0] sign-extended to 16 bits.
REQ-009 SHALL decode opcodes: 0000 R-type (RegDest=1, ALUOp=10, RegWrite=1); 0100 LW (ALU_Src=1, ALUOp=00, MemRead=1, MemtoReg=1, RegWrite=1); 0101 SW (ALU_Src=1, ALUOp=00, MemWrite=1); 0110 BEQ (ALUOp=01, Branch=1); 0111 ADDI (ALU_Src=1, ALUOp=00, RegWrite=1); others: all control 0.
REQ-010 SHALL drive all control outputs 0 when valid=0 or stall=1 (bubble); data outputs unconstrained then.
REQ-011 SHALL assert stall combinationally when valid=1, ex_MemRead=1, ex_rt!=0, and ex_rt equals rs, or equals rt for R-type/SW/BEQ.
REQ-012 SHALL drive pc_write = ~stall; flush with stall: flush wins, IF/ID squashed, pc_write=~stall as computed from pre-edge state.
REQ-013 SHALL contain an 8x16 register file: two combinational read ports (rs, rt), one write port written at rising clk when wb_RegWrite=1.
REQ-014 SHALL read register 0 as 0 and ignore writes to register 0.
REQ-015 SHALL present decoded outputs one cycle after if_instr is captured; no other latency.

Reset
REQ-016 SHALL on rst clear IF/ID (valid=0, instr=0, pc_plus_two=0) and all 8 registers to 0.
REQ-017 SHALL output all control 0, stall=0, pc_write=1 in the cycle after rst; rst mid-stall drops the held instruction.

Configuration
REQ-018 SHALL with WB_BYPASS_EN defined return wb_write_data on a read port whose address equals wb_write_reg (nonzero) while wb_RegWrite=1 in the same cycle.
REQ-019 SHALL without WB_BYPASS_EN return the pre-write register value in that case (new value visible next cycle).

Structure
REQ-020 SHALL take opcode constants, ALUOp encodings and field bit positions from a shared package mips16_pkg.
REQ-021 SHALL implement the register file as sub-module reg_file (8x16, 2R1W, reg 0 zero).

Verification
REQ-022 Reset: rst=1 one cycle, then read r1..r7 -> all 0, control 0, pc_write=1.
REQ-023 Decode: load 16'h4A85 (LW rs=5 rt=2 imm=5) -> MemRead=1, MemtoReg=1, ALU_Src=1, ALUOp=00, immediate=16'h0005; imm 6'h3F -> 16'hFFFF.
REQ-024 Load-use: ex_MemRead=1, ex_rt=2, IF/ID R-type rs=2 -> stall=1, pc_write=0, controls 0, IF/ID held next cycle; ex_rt=0 -> no stall.
REQ-025 Flush: flush=1 with stall=1 -> next cycle valid=0, all control 0.
REQ-026 Write-back: write r3=16'hBEEF, rs=3 same cycle -> Read_data_1=16'hBEEF with WB_BYPASS_EN, old value without; next cycle 16'hBEEF both; write r0=16'h1234 -> reads 0.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared MIPS16 definitions: opcode constants, ALUOp encodings, instruction
// field bit positions, the decoded control bundle and small decode helpers.
package mips16_pkg;

  localparam int unsigned DataW    = 16;
  localparam int unsigned RegAddrW = 3;
  localparam int unsigned NumRegs  = 8;

  // Instruction field bit positions
  localparam int unsigned OpcodeMsb = 15;
  localparam int unsigned OpcodeLsb = 12;
  localparam int unsigned RsMsb     = 11;
  localparam int unsigned RsLsb     = 9;
  localparam int unsigned RtMsb     = 8;
  localparam int unsigned RtLsb     = 6;
  localparam int unsigned RdMsb     = 5;
  localparam int unsigned RdLsb     = 3;
  localparam int unsigned ImmMsb    = 5;
  localparam int unsigned ImmLsb    = 0;

  // Opcodes
  localparam logic [3:0] OpRtype = 4'b0000;
  localparam logic [3:0] OpLw    = 4'b0100;
  localparam logic [3:0] OpSw    = 4'b0101;
  localparam logic [3:0] OpBeq   = 4'b0110;
  localparam logic [3:0] OpAddi  = 4'b0111;

  // ALUOp encodings
  localparam logic [1:0] AluOpAdd  = 2'b00;
  localparam logic [1:0] AluOpSub  = 2'b01;
  localparam logic [1:0] AluOpFunc = 2'b10;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_dest;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [3:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OpRtype: begin
        c.reg_dest  = 1'b1;
        c.alu_op    = AluOpFunc;
        c.reg_write = 1'b1;
      end
      OpLw: begin
        c.alu_src    = 1'b1;
        c.alu_op     = AluOpAdd;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      OpSw: begin
        c.alu_src   = 1'b1;
        c.alu_op    = AluOpAdd;
        c.mem_write = 1'b1;
      end
      OpBeq: begin
        c.alu_op = AluOpSub;
        c.branch = 1'b1;
      end
      OpAddi: begin
        c.alu_src   = 1'b1;
        c.alu_op    = AluOpAdd;
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [DataW-1:0] sign_ext6(input logic [5:0] imm);
    return {{(DataW-6){imm[5]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 8x16 register file, two combinational read ports, one clocked write port.
// Register 0 always reads as zero and ignores writes.
// Optional macro WB_BYPASS_EN: a read whose address matches an in-flight write
// (nonzero address, we=1) returns the write data in the same cycle; without it
// the old value is returned and the new one appears next cycle.
// Ports: clk, rst (sync, active-high); raddr_1/raddr_2 -> rdata_1/rdata_2;
//        we, waddr, wdata.
module reg_file
  import mips16_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [RegAddrW-1:0] raddr_1,
  input  logic [RegAddrW-1:0] raddr_2,
  output logic [DataW-1:0]    rdata_1,
  output logic [DataW-1:0]    rdata_2,
  input  logic                we,
  input  logic [RegAddrW-1:0] waddr,
  input  logic [DataW-1:0]    wdata
);

  logic [DataW-1:0] regs_q [NumRegs];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_1 = (raddr_1 == '0) ? '0 : regs_q[raddr_1];
    rdata_2 = (raddr_2 == '0) ? '0 : regs_q[raddr_2];
`ifdef WB_BYPASS_EN
    if (we && (waddr != '0) && (waddr == raddr_1)) rdata_1 = wdata;
    if (we && (waddr != '0) && (waddr == raddr_2)) rdata_2 = wdata;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// MIPS16 instruction-decode stage: IF/ID pipeline register, decoder,
// load-use hazard detection and register file.
// Optional macro WB_BYPASS_EN enables same-cycle write-back bypass in reg_file.
// Ports: clk, rst (sync, active-high); IF side if_instr/if_PC_plus_two; flush;
//        ex_MemRead/ex_rt from ID/EX; wb_* write-back port; pc_write/stall
//        hazard outputs; decoded data and control outputs toward ID/EX.
module id_stage
  import mips16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] if_instr,
  input  logic [15:0] if_PC_plus_two,
  input  logic        flush,
  input  logic        ex_MemRead,
  input  logic [2:0]  ex_rt,
  input  logic        wb_RegWrite,
  input  logic [2:0]  wb_write_reg,
  input  logic [15:0] wb_write_data,
  output logic        pc_write,
  output logic        stall,
  output logic [15:0] PC_plus_two,
  output logic [15:0] Read_data_1,
  output logic [15:0] Read_data_2,
  output logic [15:0] immediate,
  output logic        ALU_Src,
  output logic [1:0]  ALUOp,
  output logic        RegDest,
  output logic [2:0]  rt,
  output logic [2:0]  rd,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic        MemtoReg,
  output logic        RegWrite
);

  logic [15:0] instr_q;
  logic [15:0] pc_q;
  logic        valid_q;

  logic [3:0] opcode;
  logic [2:0] rs_f;
  logic [2:0] rt_f;
  logic       uses_rt;
  ctrl_t      ctrl;

  // IF/ID register: rst > flush > stall (hold) > load
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      instr_q <= if_instr;
      pc_q    <= if_PC_plus_two;
      valid_q <= 1'b1;
    end
  end

  assign opcode = instr_q[OpcodeMsb:OpcodeLsb];
  assign rs_f   = instr_q[RsMsb:RsLsb];
  assign rt_f   = instr_q[RtMsb:RtLsb];

  // rt is a source only for R-type, SW and BEQ; for LW/ADDI it is the destination
  assign uses_rt = (opcode == OpRtype) || (opcode == OpSw) || (opcode == OpBeq);

  always_comb begin
    stall = 1'b0;
    if (valid_q && ex_MemRead && (ex_rt != '0)) begin
      stall = (ex_rt == rs_f) || (uses_rt && (ex_rt == rt_f));
    end
  end

  assign pc_write = ~stall;

  // Bubble: squash controls for an empty slot or a stalled instruction
  always_comb begin
    ctrl = decode_ctrl(opcode);
    if (!valid_q || stall) ctrl = '0;
  end

  assign ALU_Src  = ctrl.alu_src;
  assign ALUOp    = ctrl.alu_op;
  assign RegDest  = ctrl.reg_dest;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign Branch   = ctrl.branch;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;

  assign PC_plus_two = pc_q;
  assign rt          = rt_f;
  assign rd          = instr_q[RdMsb:RdLsb];
  assign immediate   = sign_ext6(instr_q[ImmMsb:ImmLsb]);

  reg_file u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .raddr_1 (rs_f),
    .raddr_2 (rt_f),
    .rdata_1 (Read_data_1),
    .rdata_2 (Read_data_2),
    .we      (wb_RegWrite),
    .waddr   (wb_write_reg),
    .wdata   (wb_write_data)
  );

endmodule
